// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared types and helpers for the 10-key decimal keypad front end.
//   state_t        : debounce FSM states (IDLE, DEBOUNCE, HELD, RELEASE)
//   NUM_KEYS       : number of raw key lines (10)
//   CODE_W         : width of the binary key code (4)
//   onehot_to_idx  : one-hot key vector -> binary index 0..9
//   is_onehot      : true when exactly one key line is set
// -----------------------------------------------------------------------------
package keypad_pkg;

   localparam int NUM_KEYS = 10;
   localparam int CODE_W   = 4;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      RELEASE  = 2'd3
   } state_t;

   // OR-ing the indices of all set bits is exact for a one-hot input and
   // avoids a priority chain.
   function automatic logic [CODE_W-1:0] onehot_to_idx(input logic [NUM_KEYS-1:0] oh);
      logic [CODE_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (oh[i]) begin
            idx = idx | CODE_W'(i);
         end
      end
      return idx;
   endfunction

   function automatic logic is_onehot(input logic [NUM_KEYS-1:0] v);
      return ($countones(v) == 1);
   endfunction

endpackage

// File: rtl/keypad_sync.sv
// -----------------------------------------------------------------------------
// keypad_sync
// Two-flop synchronizer for the raw, asynchronous keypad lines.
//   clk     in   clock
//   rst     in   asynchronous active-high reset (flops clear to 0)
//   keys_i  in   raw key lines
//   keys_o  out  synchronized key lines (keys_s)
// -----------------------------------------------------------------------------
module keypad_sync
   import keypad_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_KEYS-1:0] keys_i,
   output logic [NUM_KEYS-1:0] keys_o
);

   logic [NUM_KEYS-1:0] meta_q;
   logic [NUM_KEYS-1:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= keys_i;
         sync_q <= meta_q;
      end
   end

   assign keys_o = sync_q;

endmodule

// File: rtl/keypad_ctrl.sv
// -----------------------------------------------------------------------------
// keypad_ctrl
// Debounced, multi-key-rejecting front end for the 10-key keypad. Each
// accepted press becomes one 4-bit code delivered over valid/ready.
//   clk          in   clock
//   rst          in   asynchronous active-high reset
//   keys_in      in   raw key lines (bit i = key i pressed)
//   key_code     out  binary key index 0..9
//   key_valid    out  key_code holds an undelivered event
//   key_ready    in   consumer accepts when key_valid && key_ready
//   key_overrun  out  sticky: an event was dropped (output occupied)
//   overrun_clr  in   clears key_overrun (a same-cycle overrun wins)
// Optional feature: define KEYPAD_AUTOREPEAT_EN to emit auto-repeat events
// while a key is held (REPEAT_DELAY to the first, REPEAT_RATE thereafter).
// -----------------------------------------------------------------------------
module keypad_ctrl
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_DELAY    = 16,
   parameter int REPEAT_RATE     = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_KEYS-1:0] keys_in,
   output logic [CODE_W-1:0]   key_code,
   output logic                key_valid,
   input  logic                key_ready,
   output logic                key_overrun,
   input  logic                overrun_clr
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [NUM_KEYS-1:0] keys_s;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [NUM_KEYS-1:0] cand_q, cand_d;
   logic [CODE_W-1:0]   code_q, code_d;
   logic                valid_q, valid_d;
   logic                ovr_q, ovr_d;
   logic                ev;
   logic                rpt_fire;

   keypad_sync u_sync (
      .clk    (clk),
      .rst    (rst),
      .keys_i (keys_in),
      .keys_o (keys_s)
   );

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RPT_W   = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;

   logic [RPT_W-1:0] rpt_q, rpt_d;
   logic             rpt_first_q, rpt_first_d;

   // The counter is held at zero outside HELD, so every entry into HELD
   // (from DEBOUNCE or back from a release bounce) starts a fresh delay.
   always_comb begin
      rpt_d       = rpt_q;
      rpt_first_d = rpt_first_q;
      rpt_fire    = 1'b0;
      if (state_q != HELD) begin
         rpt_d       = '0;
         rpt_first_d = 1'b1;
      end else if (keys_s != '0) begin
         if (rpt_q == (rpt_first_q ? RPT_W'(REPEAT_DELAY - 1) : RPT_W'(REPEAT_RATE - 1))) begin
            rpt_fire    = 1'b1;
            rpt_d       = '0;
            rpt_first_d = 1'b0;
         end else begin
            rpt_d = rpt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rpt_q       <= '0;
         rpt_first_q <= 1'b1;
      end else begin
         rpt_q       <= rpt_d;
         rpt_first_q <= rpt_first_d;
      end
   end
`else
   assign rpt_fire = 1'b0;
`endif

   // Debounce FSM: next state and event strobe.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cand_d  = cand_q;
      ev      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (is_onehot(keys_s)) begin
               cand_d  = keys_s;
               cnt_d   = '0;
               state_d = DEBOUNCE;
            end
         end
         DEBOUNCE: begin
            if (keys_s != cand_q) begin
               state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               state_d = HELD;
               ev      = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         HELD: begin
            // Rollover or an extra key while held is deliberately ignored.
            if (keys_s == '0) begin
               cnt_d   = '0;
               state_d = RELEASE;
            end else if (rpt_fire) begin
               ev = 1'b1;
            end
         end
         RELEASE: begin
            if (keys_s != '0) begin
               state_d = HELD;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output register: load when empty or being drained this cycle; a
   // blocked event is dropped and flagged, and beats a same-cycle clear.
   always_comb begin
      code_d  = code_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      if (overrun_clr) begin
         ovr_d = 1'b0;
      end
      if (ev) begin
         if (!valid_q || key_ready) begin
            code_d  = onehot_to_idx(cand_q);
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && key_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         cand_q  <= '0;
         code_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cand_q  <= cand_d;
         code_q  <= code_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign key_code    = code_q;
   assign key_valid   = valid_q;
   assign key_overrun = ovr_q;

endmodule

// File: tb/tb_keypad_ctrl.sv
// -----------------------------------------------------------------------------
// tb_keypad_ctrl
// Self-checking bench for keypad_ctrl: directed scenarios plus randomized
// key/handshake/reset traffic, compared every cycle against a run-length
// model of the keypad behaviour. Honours KEYPAD_AUTOREPEAT_EN if defined.
// -----------------------------------------------------------------------------
module tb_keypad_ctrl;

   localparam int D  = 4;
   localparam int RD = 16;
   localparam int RR = 8;
`ifdef KEYPAD_AUTOREPEAT_EN
   localparam bit REP_EN = 1'b1;
`else
   localparam bit REP_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] keys_in = '0;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_ready = 1'b1;
   logic       key_overrun;
   logic       overrun_clr = 1'b0;

   keypad_ctrl #(
      .DEBOUNCE_CYCLES (D),
      .REPEAT_DELAY    (RD),
      .REPEAT_RATE     (RR)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .keys_in     (keys_in),
      .key_code    (key_code),
      .key_valid   (key_valid),
      .key_ready   (key_ready),
      .key_overrun (key_overrun),
      .overrun_clr (overrun_clr)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
   endtask

   // ---------------- behavioural model ----------------
   // Keys are tracked as a confirmation run length (stable samples of one
   // candidate), a held flag, a release run of all-zero samples, and the
   // age of the current hold for auto-repeat.
   logic [9:0] m_s1, m_s2, m_cand;
   int         m_run, m_rel, m_age;
   bit         m_held, m_valid, m_ovr;
   int         m_code;
   int         m_ev_edges[$];

   // DUT-side observations
   int dut_codes[$];
   int dut_edges[$];
   int dut_valid_cycles;

   function automatic int idx_of(input logic [9:0] v);
      int r;
      r = 0;
      for (int i = 0; i < 10; i++) if (v[i]) r = i;
      return r;
   endfunction

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_cand = '0;
      m_run = 0; m_rel = 0; m_age = 0;
      m_held = 0; m_valid = 0; m_ovr = 0; m_code = 0;
   endtask

   task automatic model_step();
      logic [9:0] k;
      bit ev, drop;
      k  = m_s2;
      ev = 0;
      if (!m_held) begin
         if (m_run > 0 && k == m_cand) begin
            m_run++;
            if (m_run == D + 1) begin
               ev = 1; m_held = 1; m_rel = 0; m_age = 0;
            end
         end else if (m_run > 0) begin
            m_run = 0;
         end else if ($countones(k) == 1) begin
            m_cand = k; m_run = 1;
         end
      end else if (m_rel == 0) begin
         if (k == '0) m_rel = 1;
         else begin
            m_age++;
            if (REP_EN && (m_age == RD || (m_age > RD && (m_age - RD) % RR == 0))) ev = 1;
         end
      end else begin
         if (k != '0) begin
            m_rel = 0; m_age = 0;
         end else begin
            m_rel++;
            if (m_rel == D + 1) begin
               m_held = 0; m_run = 0; m_rel = 0;
            end
         end
      end
      drop = 0;
      if (ev) begin
         m_ev_edges.push_back(cyc);
         if (!m_valid || key_ready) begin
            m_code = idx_of(m_cand); m_valid = 1;
         end else drop = 1;
      end else if (m_valid && key_ready) m_valid = 0;
      if (drop) m_ovr = 1;
      else if (overrun_clr) m_ovr = 0;
      m_s2 = m_s1;
      m_s1 = keys_in;
   endtask

   // Model advance on the rising edge, compare on the falling edge.
   initial begin
      model_reset();
      forever begin
         @(posedge clk);
         cyc++;
         if (rst) model_reset();
         else model_step();
         @(negedge clk);
         if (rst) model_reset();
         chk("key_valid", int'(key_valid), int'(m_valid));
         chk("key_code", int'(key_code), m_code);
         chk("key_overrun", int'(key_overrun), int'(m_ovr));
         if (key_valid) dut_valid_cycles++;
         if (key_valid && key_ready) begin
            dut_codes.push_back(int'(key_code));
            dut_edges.push_back(cyc);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_logs();
      dut_codes.delete();
      dut_edges.delete();
      m_ev_edges.delete();
      dut_valid_cycles = 0;
   endtask

   int t0, tr;
   int exp_rep[$];

   initial begin
      tick(3);
      rst = 0;
      tick(2);
      chk("reset_code", int'(key_code), 0);
      chk("reset_valid", int'(key_valid), 0);

      // Clean press of key 3.
      clear_logs();
      t0 = cyc;
      keys_in = 10'b0000001000;
      tick(20);
      keys_in = '0;
      tick(20);
      chk("clean_count", dut_codes.size(), 1);
      if (dut_codes.size() > 0) begin
         chk("clean_code", dut_codes[0], 3);
         chk("clean_edge", dut_edges[0] - t0, 7);
      end
      chk("clean_valid_cycles", dut_valid_cycles, 1);
      if (m_ev_edges.size() > 0) chk("model_clean_edge", m_ev_edges[0] - t0, 7);

      // Bounce on key 5, stable from the last toggle.
      clear_logs();
      for (int i = 0; i < 5; i++) begin
         keys_in = (i % 2 == 0) ? 10'b0000100000 : 10'b0;
         t0 = cyc;
         tick(2);
      end
      tick(20);
      keys_in = '0;
      tick(20);
      chk("bounce_count", dut_codes.size(), 1);
      if (dut_codes.size() > 0) begin
         chk("bounce_code", dut_codes[0], 5);
         chk("bounce_edge", dut_edges[0] - t0, 7);
      end

      // Two keys at once: rejected.
      clear_logs();
      keys_in = 10'b0000000011;
      tick(30);
      keys_in = '0;
      tick(10);
      chk("twokey_count", dut_codes.size(), 0);
      chk("model_twokey_count", m_ev_edges.size(), 0);

      // Sweep 0..9.
      clear_logs();
      for (int i = 0; i < 10; i++) begin
         keys_in = 10'd1 << i;
         tick(10);
         keys_in = '0;
         tick(10);
      end
      chk("sweep_count", dut_codes.size(), 10);
      for (int i = 0; i < 10 && i < dut_codes.size(); i++) chk("sweep_code", dut_codes[i], i);
      chk("sweep_overrun", int'(key_overrun), 0);

      // Overrun: consumer stalled across two presses.
      clear_logs();
      key_ready = 0;
      keys_in = 10'b0000000010; tick(10); keys_in = '0; tick(10);
      keys_in = 10'b0000000100; tick(10); keys_in = '0; tick(10);
      chk("ovr_code", int'(key_code), 1);
      chk("ovr_flag", int'(key_overrun), 1);
      key_ready = 1;
      tick(5);
      chk("ovr_deliv_count", dut_codes.size(), 1);
      if (dut_codes.size() > 0) chk("ovr_deliv_code", dut_codes[0], 1);
      overrun_clr = 1; tick(1); overrun_clr = 0;
      chk("ovr_cleared", int'(key_overrun), 0);

      // Hold key 9 for 40 cycles (auto-repeat when enabled).
      clear_logs();
      t0 = cyc;
      keys_in = 10'b1000000000;
      tick(40);
      keys_in = '0;
      tick(20);
      exp_rep.delete();
      exp_rep.push_back(7);
      if (REP_EN) begin
         exp_rep.push_back(23); exp_rep.push_back(31); exp_rep.push_back(39);
      end
      chk("hold_count", dut_codes.size(), exp_rep.size());
      for (int i = 0; i < exp_rep.size() && i < dut_edges.size(); i++) begin
         chk("hold_edge", dut_edges[i] - t0, exp_rep[i]);
         chk("hold_code", dut_codes[i], 9);
      end

      // Reset in the middle of a press with an overrun pending.
      key_ready = 0;
      keys_in = 10'b0001000000; tick(10); keys_in = '0; tick(10);
      t0 = cyc;
      keys_in = 10'b0000010000;
      tick(10);
      chk("pre_rst_ovr", int'(key_overrun), 1);
      rst = 1;
      #1;
      chk("rst_valid_now", int'(key_valid), 0);
      chk("rst_ovr_now", int'(key_overrun), 0);
      key_ready = 1;
      tick(2);
      rst = 0;
      tr = cyc;
      clear_logs();
      tick(14);
      chk("rst_fresh_count", dut_codes.size(), 1);
      if (dut_codes.size() > 0) begin
         chk("rst_fresh_code", dut_codes[0], 4);
         chk("rst_fresh_edge", dut_edges[0] - tr, 7);
      end
      keys_in = '0;
      tick(20);

      // Randomized traffic against the model.
      for (int s = 0; s < 300; s++) begin
         int kind, len;
         kind = $urandom_range(0, 9);
         if (kind < 5) begin
            keys_in = 10'd1 << $urandom_range(0, 9);
            len = $urandom_range(1, 30);
         end else if (kind < 8) begin
            keys_in = '0;
            len = $urandom_range(1, 12);
         end else begin
            keys_in = 10'($urandom);
            len = $urandom_range(1, 12);
         end
         for (int c = 0; c < len; c++) begin
            key_ready   = ($urandom_range(0, 9) < 7);
            overrun_clr = ($urandom_range(0, 19) == 0);
            tick(1);
         end
         if ($urandom_range(0, 99) == 0) begin
            rst = 1;
            tick($urandom_range(1, 3));
            rst = 0;
         end
      end
      overrun_clr = 0;
      tick(5);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
